// File: rtl/conv_unit.sv
// Streaming LEN-tap 1-D convolution with valid/ready on both sides.
// Define CONV_COMB_MUL_EN to swap the shift-add multipliers for combinational ones.
module conv_unit #(
   parameter int LEN   = 4,
   parameter int WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       in_data,
   input  logic [LEN*WIDTH-1:0]   kernel,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [2*WIDTH-1:0]     result,
   output logic                   out_valid,
   input  logic                   out_ready
);

`ifdef CONV_COMB_MUL_EN
   localparam int MUL_CYCLES = 1;
`else
   localparam int MUL_CYCLES = WIDTH;
`endif
   localparam int                CNT_W    = $clog2(MUL_CYCLES + 1);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(MUL_CYCLES);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     win_q    [LEN];
   logic [WIDTH-1:0]     mplier_q [LEN];
   logic [2*WIDTH-1:0]   mcand_q  [LEN];
   logic [2*WIDTH-1:0]   acc_q    [LEN];
   logic [CNT_W-1:0]     cnt_q;
   logic [2*WIDTH-1:0]   result_q;
   logic [2*WIDTH-1:0]   sum;
   logic                 accept;

   assign accept = in_valid & in_ready;
   assign result = result_q;

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = BUSY;
         BUSY:    if (cnt_q == LAST_CNT) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

   // Products are 2*WIDTH wide; the adder tree wraps naturally at 2*WIDTH bits.
   always_comb begin
      sum = '0;
      for (int i = 0; i < LEN; i++) sum = sum + acc_q[i];
   end

   // NOTE: window and multiplier arrays are reset explicitly so a reset mid-run clears stale samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         result_q <= '0;
         for (int i = 0; i < LEN; i++) begin
            win_q[i]    <= '0;
            mplier_q[i] <= '0;
            mcand_q[i]  <= '0;
            acc_q[i]    <= '0;
         end
      end else if (accept) begin
         cnt_q       <= '0;
         win_q[0]    <= in_data;
         mcand_q[0]  <= (2*WIDTH)'(in_data);
         for (int i = 1; i < LEN; i++) begin
            win_q[i]   <= win_q[i-1];
            mcand_q[i] <= (2*WIDTH)'(win_q[i-1]);
         end
         // The multiplier operand registers double as the latched kernel copy.
         for (int i = 0; i < LEN; i++) begin
            mplier_q[i] <= kernel[i*WIDTH +: WIDTH];
            acc_q[i]    <= '0;
         end
      end else if (state_q == BUSY) begin
         if (cnt_q != LAST_CNT) begin
            cnt_q <= cnt_q + CNT_W'(1);
            for (int i = 0; i < LEN; i++) begin
`ifdef CONV_COMB_MUL_EN
               acc_q[i] <= mcand_q[i] * (2*WIDTH)'(mplier_q[i]);
`else
               if (mplier_q[i][0]) acc_q[i] <= acc_q[i] + mcand_q[i];
               mcand_q[i]  <= mcand_q[i] << 1;
               mplier_q[i] <= mplier_q[i] >> 1;
`endif
            end
         end else begin
            result_q <= sum;
         end
      end
   end

endmodule

// File: tb/tb_conv_unit.sv
// Directed self-checking bench for conv_unit: reset, sums, wrap-around, backpressure, mid-run reset.
module tb_conv_unit;
   localparam int LEN   = 4;
   localparam int WIDTH = 64;
`ifdef CONV_COMB_MUL_EN
   localparam int LAT     = 2;
   localparam int RST_DLY = 1;
`else
   localparam int LAT     = WIDTH + 1;
   localparam int RST_DLY = 20;
`endif

   logic                 clk = 1'b0;
   logic                 rst;
   logic [WIDTH-1:0]     in_data;
   logic [LEN*WIDTH-1:0] kernel;
   logic                 in_valid;
   logic                 in_ready;
   logic [2*WIDTH-1:0]   result;
   logic                 out_valid;
   logic                 out_ready;

   int passed = 0;
   int total  = 0;

   conv_unit #(.LEN(LEN), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .kernel    (kernel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .result    (result),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_kernel(input logic [WIDTH-1:0] k0, k1, k2, k3);
      kernel = {k3, k2, k1, k0};
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // Feeds one sample, scrambles the kernel while in flight, waits for out_valid.
   task automatic run_sample(input logic [WIDTH-1:0] d,
                             output logic [2*WIDTH-1:0] res, output int lat);
      logic [LEN*WIDTH-1:0] k_sav;
      k_sav    = kernel;
      in_data  = d;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      in_data  = ~d;
      kernel   = ~k_sav;
      lat      = -1;
      for (int c = 1; c <= 300; c++) begin
         step();
         if (out_valid) begin
            lat = c;
            break;
         end
      end
      res    = result;
      kernel = k_sav;
      if (out_ready) step();
   endtask

   task automatic test_reset();
      logic [2*WIDTH-1:0] res;
      int lat;
      in_valid  = 1'b1;
      in_data   = 64'd123;
      out_ready = 1'b1;
      set_kernel(64'd1, 64'd1, 64'd1, 64'd1);
      do_reset();
      in_valid = 1'b0;
      total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
      total++; if (result !== '0) $display("FAIL reset_result: got %h expected 0", result); else passed++;
      run_sample(64'd9, res, lat);
      total++; if (res !== 128'd9) $display("FAIL reset_first_result: got %0d expected 9", res); else passed++;
      total++; if (lat !== LAT) $display("FAIL reset_first_latency: got %0d expected %0d", lat, LAT); else passed++;
   endtask

   task automatic test_kernel_ones();
      logic [2*WIDTH-1:0] res;
      logic [2*WIDTH-1:0] exp [5];
      int lat;
      exp = '{128'd1, 128'd3, 128'd6, 128'd10, 128'd14};
      do_reset();
      set_kernel(64'd1, 64'd1, 64'd1, 64'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         run_sample(64'(i + 1), res, lat);
         total++; if (res !== exp[i]) $display("FAIL ones_result[%0d]: got %0d expected %0d", i, res, exp[i]); else passed++;
         total++; if (lat !== LAT) $display("FAIL ones_latency[%0d]: got %0d expected %0d", i, lat, LAT); else passed++;
         total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL ones_after_transfer[%0d]: in_ready=%b out_valid=%b expected 1/0", i, in_ready, out_valid); else passed++;
      end
   endtask

   task automatic test_two_taps();
      logic [2*WIDTH-1:0] res;
      int lat;
      do_reset();
      set_kernel(64'd2, 64'd3, 64'd0, 64'd0);
      out_ready = 1'b1;
      run_sample(64'd5, res, lat);
      total++; if (res !== 128'd10) $display("FAIL taps_first: got %0d expected 10", res); else passed++;
      run_sample(64'd7, res, lat);
      total++; if (res !== 128'd29) $display("FAIL taps_second: got %0d expected 29", res); else passed++;
   endtask

   task automatic test_wrap();
      logic [2*WIDTH-1:0] res;
      logic [2*WIDTH-1:0] exp [4];
      logic [WIDTH-1:0]   ones;
      int lat;
      ones = '1;
      exp = '{128'hFFFFFFFFFFFFFFFE_0000000000000001, 128'hFFFFFFFFFFFFFFFC_0000000000000002,
              128'hFFFFFFFFFFFFFFFA_0000000000000003, 128'hFFFFFFFFFFFFFFF8_0000000000000004};
      do_reset();
      set_kernel(ones, ones, ones, ones);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         run_sample(ones, res, lat);
         total++; if (res !== exp[i]) $display("FAIL wrap_result[%0d]: got %h expected %h", i, res, exp[i]); else passed++;
      end
   endtask

   task automatic test_backpressure();
      logic [2*WIDTH-1:0] res;
      int lat;
      do_reset();
      set_kernel(64'd1, 64'd1, 64'd1, 64'd1);
      out_ready = 1'b0;
      run_sample(64'd3, res, lat);
      total++; if (res !== 128'd3) $display("FAIL bp_result: got %0d expected 3", res); else passed++;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = 64'(100 + i);
         step();
         total++; if (result !== 128'd3 || in_ready !== 1'b0 || out_valid !== 1'b1)
            $display("FAIL bp_hold[%0d]: result=%0d in_ready=%b out_valid=%b expected 3/0/1", i, result, in_ready, out_valid);
         else passed++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); else passed++;
      total++; if (result !== 128'd3) $display("FAIL bp_result_kept: got %0d expected 3", result); else passed++;
      run_sample(64'd1, res, lat);
      total++; if (res !== 128'd4) $display("FAIL bp_no_extra_samples: got %0d expected 4", res); else passed++;
   endtask

   task automatic test_reset_mid_busy();
      logic [2*WIDTH-1:0] res;
      int lat;
      int seen;
      do_reset();
      set_kernel(64'd1, 64'd1, 64'd1, 64'd1);
      out_ready = 1'b1;
      in_data   = 64'd7;
      in_valid  = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (RST_DLY) step();
      total++; if (out_valid !== 1'b0) $display("FAIL midrst_pre: out_valid=%b expected 0", out_valid); else passed++;
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0)
         $display("FAIL midrst_state: in_ready=%b out_valid=%b result=%0d expected 1/0/0", in_ready, out_valid, result);
      else passed++;
      seen = 0;
      for (int c = 0; c < WIDTH + 5; c++) begin
         step();
         if (out_valid) seen++;
      end
      total++; if (seen !== 0) $display("FAIL midrst_no_output: got %0d out_valid cycles expected 0", seen); else passed++;
      run_sample(64'd4, res, lat);
      total++; if (res !== 128'd4) $display("FAIL midrst_window_cleared: got %0d expected 4", res); else passed++;
   endtask

   initial begin
      rst       = 1'b1;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      kernel    = '0;
      test_reset();
      test_kernel_ones();
      test_two_taps();
      test_wrap();
      test_backpressure();
      test_reset_mid_busy();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
